// File: rtl/shape_blit_ctrl.sv
// Shape blitter controller: arbitrates two draw requesters, then streams
// LINES shape-ROM lines into the frame buffer through a valid/ready write port.
module shape_blit_ctrl #(
  parameter int unsigned LINES = 60,
  parameter int unsigned W     = 51
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [1:0]   req0_orient,
  input  logic [5:0]   req0_tile,
  output logic         req0_ready,
  output logic         done0,
  input  logic         req1_valid,
  input  logic [1:0]   req1_orient,
  input  logic [5:0]   req1_tile,
  output logic         req1_ready,
  output logic         done1,
  output logic [1:0]   rom_orient,
  output logic [5:0]   rom_address,
  input  logic [W-1:0] rom_data,
  output logic         wr_valid,
  input  logic         wr_ready,
  output logic [5:0]   wr_tile,
  output logic [5:0]   wr_line,
  output logic [W-1:0] wr_data,
  output logic         busy
);

  localparam logic [5:0] LAST_LINE = 6'(LINES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OUT, DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] line;
  logic [5:0] tile_q;
  logic [1:0] orient_q;
  logic       gnt_q;   // requester owning the current draw
  logic       last_q;  // last granted requester; reset value 1 makes requester 0 win first
  logic       any_req;
  logic       pick;
  logic       grant;

  assign any_req = req0_valid | req1_valid;
  assign grant   = (state == IDLE) && any_req;

  always_comb begin
    pick = req1_valid;
    if (req0_valid && req1_valid) pick = ~last_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = OUT;
      OUT:     if (wr_ready) state_nx = (line == LAST_LINE) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line     <= '0;
      tile_q   <= '0;
      orient_q <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_valid <= 1'b0;
      wr_tile  <= '0;
      wr_line  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            orient_q <= pick ? req1_orient : req0_orient;
            tile_q   <= pick ? req1_tile   : req0_tile;
            gnt_q    <= pick;
            last_q   <= pick;
            line     <= '0;
          end
        end
        CAPTURE: begin
          wr_data  <= rom_data;
          wr_tile  <= tile_q;
          wr_line  <= line;
          wr_valid <= 1'b1;
        end
        OUT: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (line != LAST_LINE) line <= line + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ROM address/orient come straight from the line and orient registers,
  // so they are registered and hold through CAPTURE and OUT.
  assign rom_orient  = orient_q;
  assign rom_address = line;

  // Ready is a combinational grant pulse; rst gating keeps it low during reset.
  assign req0_ready = ~rst & grant & ~pick;
  assign req1_ready = ~rst & grant &  pick;
  assign done0      = (state == DONE) & ~gnt_q;
  assign done1      = (state == DONE) &  gnt_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shape_blit_ctrl.sv
// Directed + randomized bench for shape_blit_ctrl with a behavioural shape ROM
// and a per-draw reference model of grants, written lines and done timing.
module tb_shape_blit_ctrl;

  localparam int LINES = 60;
  localparam int W     = 51;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]   req0_orient = '0, req1_orient = '0;
  logic [5:0]   req0_tile = '0, req1_tile = '0;
  logic         req0_ready, req1_ready, done0, done1;
  logic [1:0]   rom_orient;
  logic [5:0]   rom_address;
  logic [W-1:0] rom_data = '0;
  logic         wr_valid;
  logic         wr_ready = 1'b0;
  logic [5:0]   wr_tile, wr_line;
  logic [W-1:0] wr_data;
  logic         busy;

  shape_blit_ctrl #(.LINES(LINES), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_orient(req0_orient), .req0_tile(req0_tile),
    .req0_ready(req0_ready), .done0(done0),
    .req1_valid(req1_valid), .req1_orient(req1_orient), .req1_tile(req1_tile),
    .req1_ready(req1_ready), .done1(done1),
    .rom_orient(rom_orient), .rom_address(rom_address), .rom_data(rom_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tile(wr_tile),
    .wr_line(wr_line), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom_line(input logic [1:0] o, input logic [5:0] a);
    logic [63:0] x;
    if (o == 2'd3) return '0;
    x = (64'(a) + 64'd1) * 64'h9E37_79B9_7F4A_7C15 ^ (64'(o) << 40) ^ 64'(o);
    return x[W-1:0];
  endfunction

  // Shape ROM: one-cycle read latency.
  always @(posedge clk) rom_data <= rom_line(rom_orient, rom_address);

  int unsigned total = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pending requests and the model's round-robin memory.
  bit         p_valid [2];
  logic [1:0] p_orient[2];
  logic [5:0] p_tile  [2];
  int         last_gnt = 1;

  task automatic drive();
    req0_valid  = p_valid[0];  req1_valid  = p_valid[1];
    req0_orient = p_orient[0]; req1_orient = p_orient[1];
    req0_tile   = p_tile[0];   req1_tile   = p_tile[1];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_valid"}, 64'(wr_valid), 0);
    chk({tag, "_busy"},     64'(busy), 0);
    chk({tag, "_ready"},    64'(req0_ready | req1_ready), 0);
    chk({tag, "_done"},     64'(done0 | done1), 0);
    chk({tag, "_rom_addr"}, 64'(rom_address), 0);
    chk({tag, "_wr_line"},  64'(wr_line), 0);
    chk({tag, "_wr_data"},  64'(wr_data), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_gnt = 1;
  endtask

  // Serve one request from the pending set and check the whole draw.
  task automatic serve_one(input int stall_line, input int abort_line,
                           input bit rand_ready, input bit expect_immediate);
    int         exp_w, wait_cyc, nxt_line, stall_left, cyc, extra;
    bit         got, hold, stalled, finished;
    logic [1:0] o;
    logic [5:0] t, hl;
    logic [W-1:0] hd;

    exp_w = (p_valid[0] && p_valid[1]) ? 1 - last_gnt : (p_valid[1] ? 1 : 0);
    o = p_orient[exp_w];
    t = p_tile[exp_w];
    got = 0;
    for (wait_cyc = 0; wait_cyc < 20; wait_cyc++) begin
      @(negedge clk);
      drive();
      wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (req0_ready || req1_ready) begin got = 1; break; end
      chk("done_single_pulse", 64'(done0 | done1), 0);
    end
    chk("grant_seen", 64'(got), 1);
    if (!got) return;
    chk("grant_winner", 64'(req1_ready), 64'(exp_w));
    chk("ready_onehot", 64'(req0_ready & req1_ready), 0);
    if (expect_immediate) chk("grant_first_idle", 64'(wait_cyc), 0);
    last_gnt = exp_w;
    p_valid[exp_w] = 0;

    nxt_line = 0; stall_left = 0; stalled = 0; hold = 0; extra = 0; finished = 0;
    for (cyc = 1; cyc < 2000; cyc++) begin
      @(negedge clk);
      drive();
      if (stall_left > 0) begin
        wr_ready = 1'b0; stall_left--;
      end else if (stall_line >= 0 && !stalled && wr_valid && int'(wr_line) == stall_line) begin
        wr_ready = 1'b0; stalled = 1; stall_left = 4; extra = 5;
      end else begin
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (abort_line >= 0 && wr_valid && int'(wr_line) == abort_line) begin
        rst = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          #1 chk("abort_no_done", 64'(done0 | done1), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        last_gnt = 1;
        return;
      end
      if (hold) begin
        chk("hold_valid", 64'(wr_valid), 1);
        chk("hold_line",  64'(wr_line), 64'(hl));
        chk("hold_data",  64'(wr_data), 64'(hd));
        hold = 0;
      end
      chk("no_grant_mid_draw", 64'(req0_ready | req1_ready), 0);
      chk("busy_in_draw", 64'(busy), 1);
      chk("rom_addr_range", 64'(rom_address < 6'(LINES)), 1);
      if (wr_valid && wr_ready) begin
        chk("wr_line", 64'(wr_line), 64'(nxt_line));
        chk("wr_tile", 64'(wr_tile), 64'(t));
        chk("wr_data", 64'(wr_data), 64'(rom_line(o, 6'(nxt_line))));
        if (o == 2'd3) chk("orient3_zero", 64'(wr_data), 0);
        nxt_line++;
      end else if (wr_valid) begin
        hold = 1; hl = wr_line; hd = wr_data;
      end
      if (done0 || done1) begin
        chk("done_owner", 64'(done1), 64'(exp_w));
        chk("done_lines", 64'(nxt_line), 64'(LINES));
        if (!rand_ready) chk("grant_to_done", 64'(cyc + 1), 64'(3 * LINES + 2 + extra));
        finished = 1;
        break;
      end
    end
    chk("done_within_budget", 64'(finished), 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin p_valid[i] = 0; p_orient[i] = '0; p_tile[i] = '0; end
    #1 check_reset_outputs("init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single draw on requester 0.
    p_valid[0] = 1; p_orient[0] = 2'd1; p_tile[0] = 6'd5;
    serve_one(-1, -1, 0, 0);

    // Contention after reset: 0, then 1 in first IDLE cycle, then 0 again.
    do_reset();
    p_valid[0] = 1; p_orient[0] = 2'd2; p_tile[0] = 6'd12;
    p_valid[1] = 1; p_orient[1] = 2'd0; p_tile[1] = 6'd40;
    serve_one(-1, -1, 0, 0);
    serve_one(-1, -1, 0, 1);
    p_valid[0] = 1; p_orient[0] = 2'd0; p_tile[0] = 6'd7;
    p_valid[1] = 1; p_orient[1] = 2'd1; p_tile[1] = 6'd63;
    serve_one(-1, -1, 0, 0);
    serve_one(-1, -1, 0, 1);

    // Backpressure at line 10.
    p_valid[0] = 1; p_orient[0] = 2'd2; p_tile[0] = 6'd33;
    serve_one(10, -1, 0, 0);

    // Reset mid-draw at line 30, then a full req1 draw.
    p_valid[0] = 1; p_orient[0] = 2'd1; p_tile[0] = 6'd9;
    serve_one(-1, 30, 0, 0);
    p_valid[1] = 1; p_orient[1] = 2'd2; p_tile[1] = 6'd21;
    serve_one(-1, -1, 0, 0);

    // Orientation 3 streams zero lines.
    p_valid[1] = 1; p_orient[1] = 2'd3; p_tile[1] = 6'd1;
    serve_one(-1, -1, 0, 0);

    // Randomized requests with random write backpressure.
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && $urandom_range(0, 1) == 1) begin
          p_valid[r] = 1; p_orient[r] = 2'($urandom); p_tile[r] = 6'($urandom);
        end
      end
      if (!p_valid[0] && !p_valid[1]) begin
        p_valid[0] = 1; p_orient[0] = 2'($urandom); p_tile[0] = 6'($urandom);
      end
      serve_one(-1, -1, 1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shape_blit_ctrl.md
SHAPE_BLIT_CTRL -- requirements
Module: shape_blit_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 60, meaning number of shape lines streamed per draw.
REQ-002 SHALL have parameter W, default 51, meaning shape line width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, draw request from requester 0 / 1.
REQ-006 SHALL have ports req0_orient / req1_orient, input, 2 each, shape orientation for the request.
REQ-007 SHALL have ports req0_tile / req1_tile, input, 6 each, destination tile index.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each, one-cycle accept pulse.
REQ-009 SHALL have ports done0 / done1, output, 1 each, one-cycle draw-complete pulse.
REQ-010 SHALL have port rom_orient, output, 2, orientation driven to the shape ROM.
REQ-011 SHALL have port rom_address, output, 6, line address driven to the shape ROM.
REQ-012 SHALL have port rom_data, input, W, ROM line, valid one cycle after rom_address/rom_orient are presented.
REQ-013 SHALL have ports wr_valid, output, 1, and wr_ready, input, 1, line-write handshake to the frame buffer.
REQ-014 SHALL have ports wr_tile, output, 6; wr_line, output, 6; and wr_data, output, W; these form the write payload.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, CAPTURE, OUT, DONE.
REQ-017 In IDLE with at least one reqN_valid, SHALL grant one requester, pulse its reqN_ready, latch its orient/tile into registers, set line=0, and enter ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both requests are valid, the requester not granted last wins; after reset, requester 0 wins.
REQ-019 Requesters SHALL hold valid and payload until ready; the block SHALL sample the payload only in the grant cycle.
REQ-020 In ISSUE, rom_orient/rom_address SHALL equal the latched orient and line; the next state SHALL be CAPTURE.
REQ-021 rom_orient/rom_address SHALL be registered and held constant through CAPTURE and OUT.
REQ-022 At the end of CAPTURE, SHALL register rom_data into wr_data, set wr_tile/wr_line, assert wr_valid, and enter OUT.
REQ-023 In OUT, wr_valid and the payload SHALL stay stable until a cycle with wr_ready=1.
REQ-024 On that wr_ready=1 cycle, wr_valid SHALL drop next cycle. If line<LINES-1, line SHALL increment and the next state SHALL be ISSUE; otherwise the next state SHALL be DONE.
REQ-025 In DONE, SHALL pulse doneN of the granted requester for exactly one cycle, then enter IDLE.
REQ-026 New requests SHALL NOT be granted outside IDLE; a request arriving mid-draw SHALL wait.
REQ-027 Orientation 3 SHALL be accepted and streamed unchanged; the ROM returns zero lines for it.
REQ-028 Minimum throughput SHALL be 3 cycles per line, i.e. 3*LINES+2 cycles from grant to done with wr_ready tied high.
REQ-029 wr_ready asserted outside OUT SHALL be ignored.
REQ-030 The line counter SHALL never exceed LINES-1, and rom_address SHALL never present a value >= LINES.

Reset
REQ-031 While rst=1, immediately and independently of clk, SHALL force state=IDLE, with wr_valid, reqN_ready, doneN and busy all 0.
REQ-032 While rst=1, SHALL clear wr_data, wr_tile, wr_line, rom_address, rom_orient and line to 0, and set the round-robin pointer to favour requester 0.
REQ-033 Reset mid-draw SHALL abandon the draw with no done pulse; operation resumes from IDLE on the first edge after rst falls.

Verification
REQ-034 Single draw: req0 with orient=1 and tile=5, wr_ready=1 -> 60 writes with wr_line 0..59 and wr_tile=5, wr_data equal to ROM orient 1 lines, one done0 pulse, 182 cycles from grant to done.
REQ-035 Contention: req0 and req1 both valid after reset -> req0 is served first, then req1; next simultaneous pair -> req0 is served first again, because the last grant was req1.
REQ-036 Backpressure: wr_ready held low for 5 cycles at line 10 -> wr_valid, wr_line=10 and wr_data stay stable, no line is skipped or duplicated.
REQ-037 Reset at line 30 -> wr_valid=0 and busy=0 asynchronously, no done0; a new req1 completes all 60 lines normally.
REQ-038 Orient 3 request -> 60 writes, all with wr_data=0, then done pulse.
REQ-039 req1 asserted during a req0 draw -> req1_ready only after done0, and the req1 grant comes in the first IDLE cycle.
